// File: rtl/nids_pkg.sv
// Shared constants, FSM state encoding and header record for the IPv4 frame builder.
package nids_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;
  localparam logic [7:0]  PROTO_TCP     = 8'd6;
  localparam logic [7:0]  PROTO_UDP     = 8'd17;

  // Byte/word positions of the last item in each fixed-length phase.
  localparam logic [15:0] CSUM_LAST  = 16'd9;
  localparam logic [15:0] HDR_LAST   = 16'd33;
  localparam logic [15:0] PORTS_LAST = 16'd37;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HDR,
    ST_PORTS,
    ST_PAYLOAD,
    ST_PAD
  } state_e;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  tos;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] ip_id;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } hdr_t;

  function automatic logic [15:0] l4_bytes(input logic [7:0] protocol);
    return ((protocol == PROTO_TCP) || (protocol == PROTO_UDP)) ? 16'd4 : 16'd0;
  endfunction

endpackage

// File: rtl/packet_builder_if.sv
// Header request, payload byte stream and frame byte stream of the frame builder.
interface packet_builder_if;

  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [7:0]  tos;
  logic [7:0]  ttl;
  logic [7:0]  protocol;
  logic [15:0] ip_id;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [10:0] payload_len;

  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;

  logic        err_len;

  modport master (
    output hdr_valid, dst_mac, src_mac, src_ip, dst_ip, tos, ttl, protocol, ip_id,
           src_port, dst_port, payload_len, pl_data, pl_valid, tx_ready,
    input  hdr_ready, pl_ready, tx_data, tx_valid, tx_last, err_len
  );

  modport slave (
    input  hdr_valid, dst_mac, src_mac, src_ip, dst_ip, tos, ttl, protocol, ip_id,
           src_port, dst_port, payload_len, pl_data, pl_valid, tx_ready,
    output hdr_ready, pl_ready, tx_data, tx_valid, tx_last, err_len
  );

endinterface

// File: rtl/ip_csum16.sv
// One's-complement 16-bit word accumulator; csum_o is the folded, inverted IPv4 checksum.
module ip_csum16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [15:0] word_i,
  output logic [15:0] csum_o
);

  // 20 bits hold ten 16-bit words without loss; carries are folded once at the end.
  logic [19:0] acc_q, acc_d;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + {4'd0, word_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign fold1  = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign fold2  = fold1[15:0] + {15'd0, fold1[16]};
  assign csum_o = ~fold2;

endmodule

// File: rtl/packet_builder.sv
// Builds Ethernet/IPv4 frames (optional L4 port pair, payload, zero pad) from a header request.
//   state      | meaning
//   ST_IDLE    | hdr_ready high, waiting for a request
//   ST_CSUM    | adding the ten IPv4 header words, one per cycle
//   ST_HDR     | emitting the 34 Ethernet + IPv4 header bytes
//   ST_PORTS   | emitting src_port, dst_port
//   ST_PAYLOAD | forwarding payload bytes from pl_* to tx_*
//   ST_PAD     | emitting zero bytes up to MIN_FRAME
module packet_builder
  import nids_pkg::*;
#(
  parameter int unsigned MAX_FRAME = 1514,
  parameter int unsigned MIN_FRAME = 60
) (
  input logic            clk,
  input logic            rst,
  packet_builder_if.slave bus
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);

  state_e      state_q, state_d;
  hdr_t        hdr_q, hdr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] pl_rem_q, pl_rem_d;
  logic [15:0] ip_len_q, ip_len_d;
  logic [15:0] out_len_q, out_len_d;
  logic        err_q, err_d;

  logic [15:0] ip_len_in, frame_len_in;
  logic        csum_clr, csum_add;
  logic [15:0] csum_word, hdr_csum;
  logic [271:0] hdr_vec;
  logic [7:0]  hdr_bytes [0:33];
  logic [7:0]  port_bytes [0:3];
  logic [1:0]  port_idx;
  logic        has_l4;
  state_e      pad_or_idle, after_ports, after_hdr;

  logic        hdr_ready, pl_ready, tx_valid, tx_last;
  logic [7:0]  tx_data;

  assign ip_len_in    = 16'd20 + l4_bytes(bus.protocol) + {5'd0, bus.payload_len};
  assign frame_len_in = 16'd14 + ip_len_in;
  assign has_l4       = (l4_bytes(hdr_q.protocol) != 16'd0);

  // Checksum word is taken as zero while summing.
  always_comb begin
    csum_word = 16'h0000;
    case (cnt_q[3:0])
      4'd0:    csum_word = {IP_VER_IHL, hdr_q.tos};
      4'd1:    csum_word = ip_len_q;
      4'd2:    csum_word = hdr_q.ip_id;
      4'd3:    csum_word = IP_FLAGS_DF;
      4'd4:    csum_word = {hdr_q.ttl, hdr_q.protocol};
      4'd5:    csum_word = 16'h0000;
      4'd6:    csum_word = hdr_q.src_ip[31:16];
      4'd7:    csum_word = hdr_q.src_ip[15:0];
      4'd8:    csum_word = hdr_q.dst_ip[31:16];
      4'd9:    csum_word = hdr_q.dst_ip[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  ip_csum16 u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (csum_clr),
    .add_i  (csum_add),
    .word_i (csum_word),
    .csum_o (hdr_csum)
  );

  always_comb begin
    hdr_vec = {hdr_q.dst_mac, hdr_q.src_mac, ETH_TYPE_IPV4, IP_VER_IHL, hdr_q.tos,
               ip_len_q, hdr_q.ip_id, IP_FLAGS_DF, hdr_q.ttl, hdr_q.protocol,
               hdr_csum, hdr_q.src_ip, hdr_q.dst_ip};
    for (int i = 0; i < 34; i++) begin
      hdr_bytes[i] = hdr_vec[271 - 8*i -: 8];
    end
    port_bytes[0] = hdr_q.src_port[15:8];
    port_bytes[1] = hdr_q.src_port[7:0];
    port_bytes[2] = hdr_q.dst_port[15:8];
    port_bytes[3] = hdr_q.dst_port[7:0];
  end

  // Ports occupy frame bytes 34..37, so the low two count bits are offset by two.
  assign port_idx = cnt_q[1:0] - 2'd2;

  // Successor phases, evaluated on the last byte of the current phase.
  always_comb begin
    pad_or_idle = ((cnt_q + 16'd1) < out_len_q) ? ST_PAD : ST_IDLE;
    after_ports = (pl_rem_q != 11'd0) ? ST_PAYLOAD : pad_or_idle;
    after_hdr   = has_l4 ? ST_PORTS : after_ports;
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    pl_rem_d  = pl_rem_q;
    ip_len_d  = ip_len_q;
    out_len_d = out_len_q;
    err_d     = 1'b0;
    csum_clr  = 1'b0;
    csum_add  = 1'b0;
    hdr_ready = 1'b0;
    pl_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        hdr_ready = 1'b1;
        if (bus.hdr_valid) begin
          hdr_d = '{dst_mac:  bus.dst_mac,  src_mac:  bus.src_mac,
                    src_ip:   bus.src_ip,   dst_ip:   bus.dst_ip,
                    tos:      bus.tos,      ttl:      bus.ttl,
                    protocol: bus.protocol, ip_id:    bus.ip_id,
                    src_port: bus.src_port, dst_port: bus.dst_port};
          pl_rem_d  = bus.payload_len;
          ip_len_d  = ip_len_in;
          out_len_d = (frame_len_in < MIN_LEN) ? MIN_LEN : frame_len_in;
          cnt_d     = 16'd0;
          csum_clr  = 1'b1;
          if (frame_len_in > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        csum_add = 1'b1;
        cnt_d    = cnt_q + 16'd1;
        if (cnt_q == CSUM_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_bytes[cnt_q[5:0]];
        if (bus.tx_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == HDR_LAST) state_d = after_hdr;
        end
      end
      ST_PORTS: begin
        tx_valid = 1'b1;
        tx_data  = port_bytes[port_idx];
        if (bus.tx_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == PORTS_LAST) state_d = after_ports;
        end
      end
      ST_PAYLOAD: begin
        pl_ready = bus.tx_ready;
        tx_valid = bus.pl_valid;
        tx_data  = bus.pl_data;
        if (bus.pl_valid && bus.tx_ready) begin
          cnt_d    = cnt_q + 16'd1;
          pl_rem_d = pl_rem_q - 11'd1;
          if (pl_rem_q == 11'd1) state_d = pad_or_idle;
        end
      end
      ST_PAD: begin
        tx_valid = 1'b1;
        if (bus.tx_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == (out_len_q - 16'd1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_last = tx_valid && (cnt_q == (out_len_q - 16'd1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hdr_q     <= '0;
      cnt_q     <= '0;
      pl_rem_q  <= '0;
      ip_len_q  <= '0;
      out_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      cnt_q     <= cnt_d;
      pl_rem_q  <= pl_rem_d;
      ip_len_q  <= ip_len_d;
      out_len_q <= out_len_d;
      err_q     <= err_d;
    end
  end

  assign bus.hdr_ready = hdr_ready;
  assign bus.pl_ready  = pl_ready;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign bus.tx_last   = tx_last;
  assign bus.err_len   = err_q;

endmodule

// File: tb/tb_packet_builder.sv
// Directed bench for packet_builder: frame contents, timing, drop, stalls and mid-frame reset.
module tb_packet_builder;
  import nids_pkg::*;

  localparam logic [47:0] DST_MAC = 48'h0011_2233_4455;
  localparam logic [47:0] SRC_MAC = 48'h6677_8899_AABB;
  localparam logic [31:0] SRC_IP  = 32'hC0A8_0001;
  localparam logic [31:0] DST_IP  = 32'hC0A8_00C7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  packet_builder_if bus ();

  packet_builder #(.MAX_FRAME(1514), .MIN_FRAME(60)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rx    [0:2047];
  logic [7:0] exp_b [0:2047];
  logic [7:0] ref_b [0:2047];
  int nrx, nlast, last_at, first_valid, first_plr, pl_idx, exp_len, ref_n;
  logic [7:0]  cur_proto;
  logic [10:0] cur_plen;
  logic [15:0] cur_id, cur_sp, cur_dp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pay(input int k);
    return 8'((k * 37 + 5) & 255);
  endfunction

  task automatic idle_inputs();
    bus.hdr_valid   = 1'b0;
    bus.dst_mac     = '0;
    bus.src_mac     = '0;
    bus.src_ip      = '0;
    bus.dst_ip      = '0;
    bus.tos         = '0;
    bus.ttl         = '0;
    bus.protocol    = '0;
    bus.ip_id       = '0;
    bus.src_port    = '0;
    bus.dst_port    = '0;
    bus.payload_len = '0;
    bus.pl_data     = '0;
    bus.pl_valid    = 1'b0;
    bus.tx_ready    = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send_hdr(input logic [7:0] proto, input logic [10:0] plen,
                          input logic [15:0] id, input logic [15:0] sp, input logic [15:0] dp);
    cur_proto = proto; cur_plen = plen; cur_id = id; cur_sp = sp; cur_dp = dp;
    bus.dst_mac = DST_MAC;  bus.src_mac = SRC_MAC;
    bus.src_ip  = SRC_IP;   bus.dst_ip  = DST_IP;
    bus.tos = 8'h00; bus.ttl = 8'h40; bus.protocol = proto; bus.ip_id = id;
    bus.src_port = sp; bus.dst_port = dp; bus.payload_len = plen;
    bus.hdr_valid = 1'b1;
    @(negedge clk);
    check("hdr_ready_idle", 32'(bus.hdr_ready), 32'd1);
    @(posedge clk); #1;
    bus.hdr_valid = 1'b0;
  endtask

  task automatic build_exp();
    logic [15:0] l4, ipl;
    logic [31:0] s;
    logic [271:0] h;
    int n;
    l4  = ((cur_proto == PROTO_TCP) || (cur_proto == PROTO_UDP)) ? 16'd4 : 16'd0;
    ipl = 16'd20 + l4 + {5'd0, cur_plen};
    s = 32'h4500 + {16'd0, ipl} + {16'd0, cur_id} + 32'h4000 + {16'd0, 8'h40, cur_proto}
      + {16'd0, SRC_IP[31:16]} + {16'd0, SRC_IP[15:0]} + {16'd0, DST_IP[31:16]} + {16'd0, DST_IP[15:0]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    h = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, ipl, cur_id, 16'h4000, 8'h40, cur_proto,
         ~s[15:0], SRC_IP, DST_IP};
    for (int i = 0; i < 34; i++) exp_b[i] = h[271 - 8*i -: 8];
    n = 34;
    if (l4 != 16'd0) begin
      exp_b[34] = cur_sp[15:8]; exp_b[35] = cur_sp[7:0];
      exp_b[36] = cur_dp[15:8]; exp_b[37] = cur_dp[7:0];
      n = 38;
    end
    for (int k = 0; k < int'(cur_plen); k++) begin
      exp_b[n] = pay(k);
      n = n + 1;
    end
    while (n < 60) begin
      exp_b[n] = 8'h00;
      n = n + 1;
    end
    exp_len = n;
  endtask

  // Drives tx_ready/payload and records the frame; stop_at > 0 stops after that many bytes.
  task automatic run_frame(input bit stall, input int budget, input int stop_at);
    bit done, prev_stall, pl_taken;
    logic [7:0] prev_data;
    logic prev_last;
    done = 1'b0; prev_stall = 1'b0; pl_taken = 1'b1; prev_data = 8'h00; prev_last = 1'b0;
    nrx = 0; nlast = 0; last_at = 0; first_valid = 0; first_plr = 0; pl_idx = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      bus.tx_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pl_taken || !bus.pl_valid) begin
        pl_taken = 1'b0;
        if (pl_idx < int'(cur_plen)) begin
          bus.pl_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
          bus.pl_data  = pay(pl_idx);
        end else begin
          bus.pl_valid = 1'b0;
          bus.pl_data  = 8'h00;
        end
      end
      @(negedge clk);
      if (first_valid == 0 && bus.tx_valid) first_valid = cyc;
      if (first_plr == 0 && bus.pl_ready) first_plr = nrx + 1;
      if (cyc == 5) check("hdr_ready_busy", 32'(bus.hdr_ready), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(bus.tx_valid), 32'd1);
        check("stall_data", 32'(bus.tx_data), 32'(prev_data));
        check("stall_last", 32'(bus.tx_last), 32'(prev_last));
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      prev_last  = bus.tx_last;
      if (bus.tx_valid && bus.tx_ready) begin
        rx[nrx] = bus.tx_data;
        nrx = nrx + 1;
        if (bus.tx_last) begin
          nlast = nlast + 1;
          last_at = nrx;
          done = 1'b1;
        end
      end
      if (bus.pl_valid && bus.pl_ready) begin
        pl_idx = pl_idx + 1;
        pl_taken = 1'b1;
      end
      @(posedge clk); #1;
      if (done || (stop_at > 0 && nrx >= stop_at)) break;
    end
    if (stop_at == 0) begin
      check("frame_done", 32'(done), 32'd1);
      bus.pl_valid = 1'b0;
      bus.tx_ready = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag);
    int bad;
    bad = -1;
    check({tag, "_len"}, nrx, exp_len);
    check({tag, "_last_at"}, last_at, exp_len);
    check({tag, "_last_count"}, nlast, 1);
    check({tag, "_pl_consumed"}, pl_idx, int'(cur_plen));
    for (int i = 0; i < exp_len && i < nrx; i++) begin
      if (rx[i] !== exp_b[i] && bad < 0) bad = i;
    end
    check({tag, "_first_bad_byte"}, bad, -1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hdr_ready"}, 32'(bus.hdr_ready), 32'd1);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_tx_last"}, 32'(bus.tx_last), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_pl_ready"}, 32'(bus.pl_ready), 32'd0);
    check({tag, "_err_len"}, 32'(bus.err_len), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int viol, bad;
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;

    // UDP, 91-byte payload: ip_len 0x0073, checksum 0xB861, 129 bytes.
    send_hdr(PROTO_UDP, 11'd91, 16'h0000, 16'h1234, 16'h5678);
    build_exp();
    run_frame(1'b0, 400, 0);
    check_frame("udp91");
    check("udp91_first_valid", first_valid, 11);
    check("udp91_nbytes", nrx, 129);
    check("udp91_last_at", last_at, 129);
    check("udp91_iplen_hi", 32'(rx[16]), 32'h00);
    check("udp91_iplen_lo", 32'(rx[17]), 32'h73);
    check("udp91_csum_hi", 32'(rx[24]), 32'hB8);
    check("udp91_csum_lo", 32'(rx[25]), 32'h61);

    // Protocol 1, empty payload: 34 header bytes + 26 zero pad bytes.
    send_hdr(8'd1, 11'd0, 16'h1234, 16'hAAAA, 16'hBBBB);
    build_exp();
    run_frame(1'b0, 200, 0);
    check_frame("icmp0");
    check("icmp0_first_valid", first_valid, 11);
    check("icmp0_last_at", last_at, 60);
    check("icmp0_byte35", 32'(rx[34]), 32'h00);
    check("icmp0_byte60", 32'(rx[59]), 32'h00);

    // Oversize UDP request (frame 1515) is dropped.
    send_hdr(PROTO_UDP, 11'd1477, 16'h0002, 16'h0001, 16'h0002);
    @(negedge clk);
    check("drop_err_pulse", 32'(bus.err_len), 32'd1);
    check("drop_no_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    check("drop_err_clear", 32'(bus.err_len), 32'd0);
    check("drop_hdr_ready", 32'(bus.hdr_ready), 32'd1);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_valid || bus.pl_ready || bus.err_len) viol = viol + 1;
    end
    check("drop_quiet", viol, 0);
    @(posedge clk); #1;

    // 100-byte payload, first without stalls, then with random tx_ready/pl_valid stalls.
    send_hdr(PROTO_UDP, 11'd100, 16'h0100, 16'h0400, 16'h0800);
    build_exp();
    run_frame(1'b0, 400, 0);
    check_frame("nostall");
    for (int i = 0; i < nrx; i++) ref_b[i] = rx[i];
    ref_n = nrx;
    send_hdr(PROTO_UDP, 11'd100, 16'h0100, 16'h0400, 16'h0800);
    run_frame(1'b1, 3000, 0);
    check_frame("stall");
    check("stall_len_vs_ref", nrx, ref_n);
    bad = -1;
    for (int i = 0; i < ref_n && i < nrx; i++) begin
      if (rx[i] !== ref_b[i] && bad < 0) bad = i;
    end
    check("stall_vs_ref", bad, -1);

    // Reset while byte 40 of a 200-byte frame is offered.
    send_hdr(PROTO_UDP, 11'd162, 16'h0200, 16'h0011, 16'h0022);
    run_frame(1'b0, 400, 39);
    check("rst_pre_bytes", nrx, 39);
    check("rst_pre_byte40_valid", 32'(bus.tx_valid), 32'd1);
    bus.tx_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.pl_valid = 1'b0;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    check("midrst_pl_consumed", pl_idx, 1);
    @(posedge clk); #1;

    // TCP after reset: ports 1F90/0050, payload starts at byte 39, pad to 60.
    send_hdr(PROTO_TCP, 11'd10, 16'hBEEF, 16'h1F90, 16'h0050);
    build_exp();
    run_frame(1'b0, 200, 0);
    check_frame("tcp");
    check("tcp_first_valid", first_valid, 11);
    check("tcp_byte35", 32'(rx[34]), 32'h1F);
    check("tcp_byte36", 32'(rx[35]), 32'h90);
    check("tcp_byte37", 32'(rx[36]), 32'h00);
    check("tcp_byte38", 32'(rx[37]), 32'h50);
    check("tcp_first_pl_ready", first_plr, 39);
    check("tcp_last_at", last_at, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
